// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - round-robin arbiter sharing one memory port between I-refill and data sides
// Optional ARB_STATS_EN adds grant counters and a data-side wait-cycle counter.
module imem_dmem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [31:0]       d_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_d_wait_cycles
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_lock;
  logic             w_gnt_i;
  logic             w_gnt_d;
  logic             w_done;

  // Grants are masked during reset so a late mem_ready cannot complete an aborted access.
  assign w_gnt_i   = (r_state == ST_GNT_I) && !reset;
  assign w_gnt_d   = (r_state == ST_GNT_D) && !reset;
  assign w_lock    = (r_burst_cnt != '0);
  assign w_cnt_inc = r_burst_cnt + CNT_W'(1);

  assign mem_valid = (w_gnt_i && i_valid) || (w_gnt_d && d_valid);
  assign mem_instr = w_gnt_i;
  assign mem_addr  = w_gnt_i ? i_addr : (w_gnt_d ? d_addr : '0);
  assign mem_wdata = w_gnt_d ? d_wdata : '0;
  assign mem_wstrb = w_gnt_d ? d_wstrb : '0;
  assign w_done    = mem_ready && mem_valid;
  assign i_ready   = w_gnt_i && w_done;
  assign d_ready   = w_gnt_d && w_done;
  assign i_rdata   = w_gnt_i ? mem_rdata : '0;
  assign d_rdata   = w_gnt_d ? mem_rdata : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_lock && i_valid) begin
          w_state_nxt = ST_GNT_I;
        end else begin
          if (w_lock) w_burst_nxt = '0;
          if (i_valid && d_valid) w_state_nxt = r_last_grant ? ST_GNT_I : ST_GNT_D;
          else if (i_valid)       w_state_nxt = ST_GNT_I;
          else if (d_valid)       w_state_nxt = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
          w_burst_nxt = (w_cnt_inc == CNT_W'(BURST_LEN)) ? '0 : w_cnt_inc;
        end else if (!i_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
          w_burst_nxt = '0;
        end else if (!d_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_stat_i;
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
      r_stat_w <= '0;
    end else begin
      if (i_ready && (r_stat_i != '1)) r_stat_i <= r_stat_i + 32'd1;
      if (d_ready && (r_stat_d != '1)) r_stat_d <= r_stat_d + 32'd1;
      if (d_valid && (r_state != ST_GNT_D) && (r_stat_w != '1)) r_stat_w <= r_stat_w + 32'd1;
    end
  end

  assign stat_i_grants      = r_stat_i;
  assign stat_d_grants      = r_stat_d;
  assign stat_d_wait_cycles = r_stat_w;
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - scoreboard bench for imem_dmem_arbiter (BURST_LEN 4 and 1 instances)
// Stat counters are checked only when ARB_STATS_EN is defined.
module tb_imem_dmem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready, d_valid, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        rr_i_valid, rr_i_ready, rr_d_valid, rr_d_ready;
  logic        rr_mem_valid, rr_mem_instr, rr_mem_ready;
  logic [31:0] rr_i_rdata, rr_d_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
  logic [3:0]  rr_mem_wstrb;
  logic [31:0] rr_i_addr, rr_d_addr, rr_d_wdata;
  logic [3:0]  rr_d_wstrb;

`ifdef ARB_STATS_EN
  logic [31:0] stat_i, stat_d, stat_w, rr_stat_i, rr_stat_d, rr_stat_w;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lat     = 0;
  int   wcnt    = 0;
  bit   i_done_s, d_done_s;
  req_t i_cmd[$], d_cmd[$], exp_i[$], exp_d[$];
  bit   exp_side[$];
  bit   rr_side[$];
  int   rr_cyc[$];

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.BURST_LEN(4), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_i_grants(stat_i), .stat_d_grants(stat_d), .stat_d_wait_cycles(stat_w)
`endif
  );

  imem_dmem_arbiter #(.BURST_LEN(1), .ADDR_W(32)) u_rr (
    .clk(clk), .reset(reset),
    .i_valid(rr_i_valid), .i_ready(rr_i_ready), .i_addr(rr_i_addr), .i_rdata(rr_i_rdata),
    .d_valid(rr_d_valid), .d_ready(rr_d_ready), .d_addr(rr_d_addr), .d_wdata(rr_d_wdata),
    .d_wstrb(rr_d_wstrb), .d_rdata(rr_d_rdata),
    .mem_valid(rr_mem_valid), .mem_instr(rr_mem_instr), .mem_ready(rr_mem_ready),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wstrb(rr_mem_wstrb), .mem_rdata(rr_mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_i_grants(rr_stat_i), .stat_d_grants(rr_stat_d), .stat_d_wait_cycles(rr_stat_w)
`endif
  );

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata    = {16'h1234, mem_addr[15:0]};
  assign rr_mem_ready = rr_mem_valid;
  assign rr_mem_rdata = 32'h0;
  assign rr_i_addr    = 32'h10;
  assign rr_d_addr    = 32'h20;
  assign rr_d_wdata   = 32'h0;
  assign rr_d_wstrb   = 4'h0;

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return {16'h1234, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_i(input logic [31:0] a);
    req_t r;
    r.addr = a; r.wdata = '0; r.wstrb = '0; r.rdata = model_rdata(a);
    i_cmd.push_back(r);
    exp_i.push_back(r);
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    req_t r;
    r.addr = a; r.wdata = wd; r.wstrb = ws; r.rdata = model_rdata(a);
    d_cmd.push_back(r);
    exp_d.push_back(r);
  endtask

  task automatic clear_queues();
    i_cmd.delete(); d_cmd.delete(); exp_i.delete(); exp_d.delete(); exp_side.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_queues();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_side.size() != 0 || i_valid || d_valid) && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= 200), 32'd0);
  endtask

  // Requester agents: raise valid for the head command, drop it the cycle after ready.
  always @(negedge clk) begin
    i_done_s = i_ready;
    d_done_s = d_ready;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      i_valid = 1'b0;
      d_valid = 1'b0;
    end else begin
      if (i_valid && i_done_s) begin
        void'(i_cmd.pop_front());
        i_valid = 1'b0;
      end
      if (!i_valid && i_cmd.size() > 0) begin
        i_valid = 1'b1;
        i_addr  = i_cmd[0].addr;
      end
      if (d_valid && d_done_s) begin
        void'(d_cmd.pop_front());
        d_valid = 1'b0;
      end
      if (!d_valid && d_cmd.size() > 0) begin
        d_valid = 1'b1;
        d_addr  = d_cmd[0].addr;
        d_wdata = d_cmd[0].wdata;
        d_wstrb = d_cmd[0].wstrb;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (mem_valid) begin
      if (wcnt >= lat) begin
        mem_ready = 1'b1;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  always @(posedge clk) cyc++;

  // Scoreboard monitor on completions of the main instance.
  always @(negedge clk) begin
    req_t e;
    bit   s;
    if (!reset && (i_ready || d_ready)) begin
      chk("both_ready", 32'(i_ready && d_ready), 32'd0);
      if (exp_side.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        s = exp_side.pop_front();
        chk("grant_side", 32'(d_ready), 32'(s));
      end
      if (i_ready && exp_i.size() > 0) begin
        e = exp_i.pop_front();
        chk("i_addr", mem_addr, e.addr);
        chk("i_wdata", mem_wdata, 32'd0);
        chk("i_wstrb", 32'(mem_wstrb), 32'd0);
        chk("i_instr", 32'(mem_instr), 32'd1);
        chk("i_rdata", i_rdata, e.rdata);
        chk("i_d_rdata_zero", d_rdata, 32'd0);
      end
      if (d_ready && exp_d.size() > 0) begin
        e = exp_d.pop_front();
        chk("d_addr", mem_addr, e.addr);
        chk("d_wdata", mem_wdata, e.wdata);
        chk("d_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        chk("d_instr", 32'(mem_instr), 32'd0);
        chk("d_rdata", d_rdata, e.rdata);
        chk("d_i_rdata_zero", i_rdata, 32'd0);
      end
    end
    if (!reset && rr_i_ready) begin rr_side.push_back(1'b0); rr_cyc.push_back(cyc); end
    if (!reset && rr_d_ready) begin rr_side.push_back(1'b1); rr_cyc.push_back(cyc); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0;
    rr_i_valid = 1'b0; rr_d_valid = 1'b0;
    step(); step();
    rr_i_valid = 1'b1;
    rr_d_valid = 1'b1;
    step();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_mem_instr", 32'(mem_instr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rr_mem_valid", 32'(rr_mem_valid), 32'd0);
    reset = 1'b0;

    // Strict alternation with BURST_LEN = 1, starting with I.
    repeat (8) step();
    rr_i_valid = 1'b0;
    rr_d_valid = 1'b0;
    step(); step();
    chk("rr_grant_count", 32'(rr_side.size()), 32'd4);
    for (int k = 0; k < 4 && k < rr_side.size(); k++) begin
      chk($sformatf("rr_side_%0d", k), 32'(rr_side[k]), 32'(k % 2));
      if (k > 0) chk($sformatf("rr_gap_%0d", k), 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd2);
    end

    // Single D write with zero-wait memory.
    push_d(32'h100, 32'hDEADBEEF, 4'b1111);
    exp_side.push_back(1'b1);
    step();
    chk("w_valid_before", 32'(mem_valid), 32'd0);
    step();
    chk("w_mem_valid", 32'(mem_valid), 32'd1);
    chk("w_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("w_mem_instr", 32'(mem_instr), 32'd0);
    chk("w_d_ready", 32'(d_ready), 32'd1);
    chk("w_i_ready", 32'(i_ready), 32'd0);
    step();
    chk("w_d_ready_pulse", 32'(d_ready), 32'd0);
    chk("w_bubble", 32'(mem_valid), 32'd0);
    wait_done("w_timeout");

    // Four-word I refill holds off a pending D.
    do_reset();
    push_i(32'h200); push_i(32'h204); push_i(32'h208); push_i(32'h20C);
    repeat (4) exp_side.push_back(1'b0);
    step();
    push_d(32'h300, 32'hCAFEF00D, 4'b0011);
    exp_side.push_back(1'b1);
    wait_done("burst_timeout");
    chk("burst_all_done", 32'(exp_i.size() + exp_d.size()), 32'd0);
`ifdef ARB_STATS_EN
    chk("stat_d_wait", stat_w, 32'd8);
    chk("stat_i_grants", stat_i, 32'd4);
    chk("stat_d_grants", stat_d, 32'd1);
`endif

    // Lock dropped after two words: D wins the next IDLE.
    do_reset();
    push_i(32'h240); push_i(32'h244);
    exp_side.push_back(1'b0); exp_side.push_back(1'b0);
    step();
    push_d(32'h310, 32'h0, 4'b0000);
    exp_side.push_back(1'b1);
    n = 0;
    while (!(mem_valid && !mem_instr) && n < 50) begin step(); n++; end
    chk("drop_dgrant_timeout", 32'(n >= 50), 32'd0);
    chk("drop_burst_cnt", 32'(u_dut.r_burst_cnt), 32'd0);
    chk("drop_i_left", 32'(exp_i.size()), 32'd0);
    wait_done("drop_timeout");

    // Reset in the second wait cycle of a 3-cycle D access.
    do_reset();
    lat = 3;
    push_d(32'h400, 32'h0, 4'b0000);
    n = 0;
    while (!(mem_valid && !mem_instr) && n < 50) begin step(); n++; end
    chk("abort_grant_timeout", 32'(n >= 50), 32'd0);
    step();
    reset = 1'b1;
    clear_queues();
    #1;
    chk("abort_valid_in_reset", 32'(mem_valid), 32'd0);
    chk("abort_ready_in_reset", 32'(d_ready), 32'd0);
    step();
    chk("abort_valid_after", 32'(mem_valid), 32'd0);
    chk("abort_d_ready", 32'(d_ready), 32'd0);
    chk("abort_state_idle", 32'(u_dut.r_state), 32'd0);
    reset = 1'b0;
    lat = 0;

    // Fresh I read after the abort; data routed only to the I side.
    push_i(32'h5678);
    exp_side.push_back(1'b0);
    n = 0;
    while (!i_ready && n < 50) begin step(); n++; end
    chk("rd_ready_timeout", 32'(n >= 50), 32'd0);
    chk("rd_i_rdata", i_rdata, 32'h12345678);
    chk("rd_d_rdata", d_rdata, 32'd0);
    wait_done("rd_timeout");
    chk("end_d_ready_idle", 32'(d_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one unified memory port between two requesters:
  - the I-cache refill port (read-only);
  - the processor data port (read/write).
- Replaces the split imem/dmem arrangement in the testbench.
- Uses the same valid/ready handshake on all sides.
- Round-robin arbitration, with an optional instruction-burst lock so that cache-line refills complete back-to-back.

Parameters:
- BURST_LEN, 4: words per I-cache refill. The instruction lock holds for up to BURST_LEN consecutive instruction grants. 1 disables locking.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  I-cache refill request
- i_ready  out  1  one-cycle completion pulse to I-cache
- i_addr  in  ADDR_W  refill word address
- i_rdata  out  32  read data to I-cache
- d_valid  in  1  data request
- d_ready  out  1  one-cycle completion pulse to data side
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  write data
- d_wstrb  in  4  byte strobes; 0 = read
- d_rdata  out  32  read data to data side
- mem_valid  out  1  request to memory
- mem_instr  out  1  1 when the instruction side owns the port
- mem_ready  in  1  memory completion pulse
- mem_addr  out  ADDR_W  muxed address
- mem_wdata  out  32  muxed write data (0 during instruction grant)
- mem_wstrb  out  4  muxed strobes (0 during instruction grant)
- mem_rdata  in  32  memory read data

Behaviour:
- Registered state: IDLE, GNT_I, GNT_D.
- Also registered: last_grant (0 = I, 1 = D) and burst_cnt (clog2(BURST_LEN)+1 bits).
- Reset (sync, active-high):
  - state = IDLE, last_grant = D, burst_cnt = 0.
  - Outputs during and after reset: mem_valid = 0, i_ready = 0, d_ready = 0, mem_instr = 0, mem_addr/wdata/wstrb = 0.
- Reset mid-transaction aborts the grant. Any mem_ready arriving in the reset cycle is ignored and not forwarded.
- IDLE: outputs idle; decision registered at the clock edge. Priority order:
  - lock active (burst_cnt != 0) and i_valid -> GNT_I;
  - lock active and !i_valid -> lock dropped (burst_cnt = 0), then normal arbitration in the same cycle;
  - only i_valid -> GNT_I;
  - only d_valid -> GNT_D;
  - both valid -> grant the side opposite last_grant.
- GNT_x, memory side:
  - mem_valid = x_valid, combinational;
  - addr, wdata and wstrb muxed from x;
  - mem_instr = (state == GNT_I).
- GNT_x, requester side:
  - x_ready = mem_ready & mem_valid, combinational;
  - x_rdata = mem_rdata.
  - The non-granted ready is always 0; its rdata is held at 0.
- Completion (mem_ready & mem_valid): state -> IDLE, last_grant <= x.
  - On GNT_I: burst_cnt <= (burst_cnt+1 == BURST_LEN) ? 0 : burst_cnt+1.
  - On GNT_D: burst_cnt <= 0.
- Latency:
  - request seen in IDLE at edge N -> mem_valid high in cycle N+1;
  - one IDLE bubble between consecutive transactions;
  - minimum 2 cycles per access with zero-wait memory.
- Granted requester drops valid before ready (protocol violation): mem_valid falls with it; state -> IDLE at next edge; no ready issued; last_grant unchanged.
- mem_ready while !mem_valid: ignored.
- Fairness:
  - with both sides continuously requesting and BURST_LEN = 1, grants strictly alternate;
  - with a lock active, D waits at most BURST_LEN instruction grants.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs stat_i_grants (32), stat_d_grants (32) and stat_d_wait_cycles (32).
  - Grant counters increment on each completion for their side.
  - The wait counter increments every cycle that d_valid = 1 and the state is not GNT_D.
  - All counters clear on reset and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Single D write, zero-wait memory:
  - stimulus: d_addr = 0x100, d_wdata = 0xDEADBEEF, d_wstrb = 4'b1111;
  - response: mem_valid rises one cycle after d_valid, mem_wstrb = 1111, d_ready pulses one cycle, i_ready stays 0, mem_instr = 0.
- I and D both valid continuously, BURST_LEN = 1, zero-wait:
  - response: after reset, grants go I, D, I, D (last_grant reset = D);
  - each grant lasts 1 cycle plus a 1-cycle IDLE bubble.
- BURST_LEN = 4, I refill of 0x200..0x20C with d_valid held high:
  - response: four consecutive I grants, then D is granted;
  - stat_d_wait_cycles = 8 with the feature enabled.
- Lock drop:
  - stimulus: BURST_LEN = 4; I deasserts valid after 2 words while d_valid is high;
  - response: D is granted at the next IDLE, burst_cnt = 0.
- Reset during GNT_D with 3-cycle memory latency:
  - stimulus: assert reset in wait cycle 2;
  - response: next cycle mem_valid = 0, d_ready never pulses, state = IDLE, a new I request is granted normally.
- Read data routing:
  - stimulus: mem_rdata = 0x12345678 during GNT_I;
  - response: i_rdata = 0x12345678 and d_rdata = 0 in the ready cycle.
